// File: rtl/imm_arb_ctrl.sv
// Round-robin arbiter and write sequencer for the 8-bit immediate register.
// Keeps a shadow copy of the register so that bit-clear writes are computed locally.
module imm_arb_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       dec_req,
   input  logic       dec_op,
   input  logic [7:0] dec_data,
   input  logic [2:0] dec_bit,
   output logic       dec_gnt,
   input  logic       dbg_req,
   input  logic       dbg_op,
   input  logic [7:0] dbg_data,
   input  logic [2:0] dbg_bit,
   output logic       dbg_gnt,
   input  logic       dbg_lock,
   output logic       imm_en_n,
   output logic [7:0] imm_data,
   output logic [2:0] imm_clear,
   output logic [7:0] shadow,
   output logic       done,
   output logic       busy,
   output logic [7:0] op_count
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] WRITE  = 2'd1;
   localparam logic [1:0] SETTLE = 2'd2;

   localparam logic OP_LOAD = 1'b0;

   logic [1:0] state_q,     state_d;
   logic       last_dbg_q,  last_dbg_d;
   logic       imm_en_n_q,  imm_en_n_d;
   logic [7:0] imm_data_q,  imm_data_d;
   logic [2:0] imm_clear_q, imm_clear_d;
   logic       dec_gnt_q,   dec_gnt_d;
   logic       dbg_gnt_q,   dbg_gnt_d;
   logic       done_q,      done_d;
   logic       busy_q,      busy_d;
   logic [7:0] shadow_q,    shadow_d;
   logic [7:0] op_count_q,  op_count_d;

   logic       dec_vld;
   logic       any_req;
   logic       pick_dbg;
   logic       win_op;
   logic [7:0] win_data;
   logic [2:0] win_bit;

   // dbg_lock masks the decoder; on a tie the side that lost last time wins.
   always_comb begin
      dec_vld  = dec_req & ~dbg_lock;
      any_req  = dec_vld | dbg_req;
      pick_dbg = dbg_req & (~dec_vld | ~last_dbg_q);
      win_op   = pick_dbg ? dbg_op   : dec_op;
      win_data = pick_dbg ? dbg_data : dec_data;
      win_bit  = pick_dbg ? dbg_bit  : dec_bit;
   end

   always_comb begin
      state_d     = state_q;
      last_dbg_d  = last_dbg_q;
      imm_en_n_d  = 1'b1;
      imm_data_d  = imm_data_q;
      imm_clear_d = imm_clear_q;
      dec_gnt_d   = 1'b0;
      dbg_gnt_d   = 1'b0;
      done_d      = 1'b0;
      shadow_d    = shadow_q;
      op_count_d  = op_count_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               // The write value is formed here so it is registered for the WRITE cycle.
               state_d    = WRITE;
               last_dbg_d = pick_dbg;
               imm_en_n_d = 1'b0;
               dec_gnt_d  = ~pick_dbg;
               dbg_gnt_d  = pick_dbg;
               if (win_op == OP_LOAD) begin
                  imm_data_d  = win_data;
                  imm_clear_d = 3'd0;
               end else begin
                  imm_data_d  = shadow_q & ~(8'd1 << win_bit);
                  imm_clear_d = win_bit;
               end
            end
         end
         WRITE: begin
            state_d    = SETTLE;
            shadow_d   = imm_data_q;
            done_d     = 1'b1;
            op_count_d = op_count_q + 8'd1;
         end
         SETTLE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_dbg_q  <= 1'b1;
         imm_en_n_q  <= 1'b1;
         imm_data_q  <= 8'd0;
         imm_clear_q <= 3'd0;
         dec_gnt_q   <= 1'b0;
         dbg_gnt_q   <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         shadow_q    <= 8'd0;
         op_count_q  <= 8'd0;
      end else begin
         state_q     <= state_d;
         last_dbg_q  <= last_dbg_d;
         imm_en_n_q  <= imm_en_n_d;
         imm_data_q  <= imm_data_d;
         imm_clear_q <= imm_clear_d;
         dec_gnt_q   <= dec_gnt_d;
         dbg_gnt_q   <= dbg_gnt_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         shadow_q    <= shadow_d;
         op_count_q  <= op_count_d;
      end
   end

   assign imm_en_n  = imm_en_n_q;
   assign imm_data  = imm_data_q;
   assign imm_clear = imm_clear_q;
   assign dec_gnt   = dec_gnt_q;
   assign dbg_gnt   = dbg_gnt_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign shadow    = shadow_q;
   assign op_count  = op_count_q;

endmodule
